// File: rtl/hilo_unit.sv
// HI/LO unit: mthi/mtlo, iterative radix-2 mult/div with forwarding strobes.
// Define HILO_FAST_MUL_EN for single-cycle mult/multu; div stays iterative.
module hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [5:0]  hilo_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stallreq,
    output logic [1:0]  hilo_we,
    output logic [31:0] hi_i,
    output logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [64:0] acc, acc_nx;
    logic [31:0] opnd, op_a;
    logic        neg_q, neg_r, div0, is_mul;

    logic sel_div, sel_divu, sel_mult, sel_multu, sel_mthi, sel_mtlo;
    logic accept, is_signed, neg_a, neg_b, it_op, fast_mul;
    logic [31:0] mag_a, mag_b;
    logic [63:0] fast_prod;

    always_comb begin
        sel_div   = 1'b0;
        sel_divu  = 1'b0;
        sel_mult  = 1'b0;
        sel_multu = 1'b0;
        sel_mthi  = 1'b0;
        sel_mtlo  = 1'b0;
        priority case (1'b1)
            hilo_op[5]: sel_div   = 1'b1;
            hilo_op[4]: sel_divu  = 1'b1;
            hilo_op[3]: sel_mult  = 1'b1;
            hilo_op[2]: sel_multu = 1'b1;
            hilo_op[1]: sel_mthi  = 1'b1;
            hilo_op[0]: sel_mtlo  = 1'b1;
            default: ;
        endcase
    end

    assign accept    = !rst && state == IDLE && op_valid && !flush;
    assign is_signed = sel_div | sel_mult;
    assign neg_a     = is_signed & src_a[31];
    assign neg_b     = is_signed & src_b[31];
    assign mag_a     = neg_a ? -src_a : src_a;
    assign mag_b     = neg_b ? -src_b : src_b;

`ifdef HILO_FAST_MUL_EN
    logic [63:0] prod_u;
    assign fast_mul  = 1'b1;
    assign prod_u    = {32'd0, mag_a} * {32'd0, mag_b};
    assign fast_prod = (neg_a ^ neg_b) ? -prod_u : prod_u;
`else
    assign fast_mul  = 1'b0;
    assign fast_prod = 64'd0;
`endif

    assign it_op = sel_div | sel_divu | ((sel_mult | sel_multu) & !fast_mul);

    // acc holds {rem, quot} for div and {partial, multiplier} for mult
    logic [32:0] rem_sh, rem_sub, mul_sum;
    always_comb begin
        rem_sh  = {acc[63:32], acc[31]};
        rem_sub = rem_sh - {1'b0, opnd};
        mul_sum = acc[64:32] + (acc[0] ? {1'b0, opnd} : 33'd0);
        if (state == MUL)
            acc_nx = {1'b0, mul_sum, acc[31:1]};
        else if (rem_sh >= {1'b0, opnd})
            acc_nx = {rem_sub, acc[30:0], 1'b1};
        else
            acc_nx = {rem_sh, acc[30:0], 1'b0};
    end

    logic [63:0] prod, done_res;
    logic [31:0] quot, rem;
    always_comb begin
        prod = neg_q ? -acc[63:0] : acc[63:0];
        quot = neg_q ? -acc[31:0] : acc[31:0];
        rem  = neg_r ? -acc[63:32] : acc[63:32];
        if (is_mul)
            done_res = prod;
        else if (div0)
            done_res = {op_a, 32'hFFFF_FFFF};
        else
            done_res = {rem, quot};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && (sel_div | sel_divu))
                    state_nx = DIV;
                else if (accept && it_op)
                    state_nx = MUL;
            end
            MUL, DIV: begin
                if (flush)
                    state_nx = IDLE;
                else if (cnt == 5'd31)
                    state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        stallreq = 1'b0;
        hilo_we  = 2'b00;
        hi_i     = 32'd0;
        lo_i     = 32'd0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (it_op) begin
                            stallreq = 1'b1;
                        end else if (sel_mult | sel_multu) begin
                            hilo_we      = 2'b11;
                            {hi_i, lo_i} = fast_prod;
                        end else if (sel_mthi) begin
                            hilo_we = 2'b10;
                            hi_i    = src_a;
                        end else if (sel_mtlo) begin
                            hilo_we = 2'b01;
                            lo_i    = src_a;
                        end
                    end
                end
                MUL, DIV: stallreq = 1'b1;
                DONE: begin
                    if (!flush) begin
                        hilo_we      = 2'b11;
                        {hi_i, lo_i} = done_res;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 5'd0;
            acc    <= 65'd0;
            opnd   <= 32'd0;
            op_a   <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            is_mul <= 1'b0;
            hi_o   <= 32'd0;
            lo_o   <= 32'd0;
        end else begin
            if (accept) begin
                cnt    <= 5'd0;
                acc    <= {33'd0, mag_a};
                opnd   <= mag_b;
                op_a   <= src_a;
                neg_q  <= neg_a ^ neg_b;
                neg_r  <= neg_a;
                div0   <= src_b == 32'd0;
                is_mul <= sel_mult | sel_multu;
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt + 5'd1;
                acc <= acc_nx;
            end
            if (hilo_we[1])
                hi_o <= hi_i;
            if (hilo_we[0])
                lo_o <= lo_i;
        end
    end
endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: writes are matched against a queue
// of results computed by a behavioural model when each op is driven.
module tb_hilo_unit;
    logic        clk = 1'b0;
    logic        rst, op_valid, flush;
    logic [5:0]  hilo_op;
    logic [31:0] src_a, src_b;
    logic        stallreq;
    logic [1:0]  hilo_we;
    logic [31:0] hi_i, lo_i, hi_o, lo_o;

    localparam logic [5:0] OP_DIV   = 6'b100000;
    localparam logic [5:0] OP_DIVU  = 6'b010000;
    localparam logic [5:0] OP_MULT  = 6'b001000;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000010;
    localparam logic [5:0] OP_MTLO  = 6'b000001;

    hilo_unit dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .hilo_op(hilo_op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .stallreq(stallreq), .hilo_we(hilo_we),
        .hi_i(hi_i), .lo_i(lo_i), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(logic [5:0] op, logic [31:0] a,
                                   logic [31:0] b);
        exp_t        e;
        longint      sa, sb;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        e.we = 2'b11;
        e.hi = 32'd0;
        e.lo = 32'd0;
        if (op[5] | op[4]) begin
            if (b == 32'd0) begin
                e.hi = a;
                e.lo = 32'hFFFF_FFFF;
            end else if (op[5]) begin
                e.lo = 32'(sa / sb);
                e.hi = 32'(sa % sb);
            end else begin
                e.lo = a / b;
                e.hi = a % b;
            end
        end else if (op[3]) begin
            p = 64'(sa * sb);
            {e.hi, e.lo} = p;
        end else if (op[2]) begin
            p = {32'd0, a} * {32'd0, b};
            {e.hi, e.lo} = p;
        end else if (op[1]) begin
            e.we = 2'b10;
            e.hi = a;
        end else begin
            e.we = 2'b01;
            e.lo = a;
        end
        return e;
    endfunction

    function automatic int exp_stalls(logic [5:0] op);
`ifdef HILO_FAST_MUL_EN
        return (op[5] | op[4]) ? 33 : 0;
`else
        return (op[5] | op[4] | op[3] | op[2]) ? 33 : 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && hilo_we != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {62'd0, hilo_we}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("we", {62'd0, hilo_we}, {62'd0, mon_e.we});
                if (mon_e.we[1])
                    chk("hi_i", {32'd0, hi_i}, {32'd0, mon_e.hi});
                if (mon_e.we[0])
                    chk("lo_i", {32'd0, lo_i}, {32'd0, mon_e.lo});
            end
        end
    end

    task automatic run_op(string tag, logic [5:0] op, logic [31:0] a,
                          logic [31:0] b);
        exp_t e;
        int   stalls = 0;
        bit   done = 1'b0;
        e = model(op, a, b);
        @(posedge clk); #1;
        op_valid = 1'b1;
        hilo_op  = op;
        src_a    = a;
        src_b    = b;
        exp_q.push_back(e);
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (stallreq)
                stalls++;
            if (hilo_we != 2'b00)
                done = 1'b1;
        end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls(op)));
        @(posedge clk); #1;
        op_valid = 1'b0;
        hilo_op  = 6'd0;
        if (e.we[1]) m_hi = e.hi;
        if (e.we[0]) m_lo = e.lo;
        @(negedge clk);
        chk({tag, "_hi_o"}, {32'd0, hi_o}, {32'd0, m_hi});
        chk({tag, "_lo_o"}, {32'd0, lo_o}, {32'd0, m_lo});
        chk({tag, "_idle"}, {62'd0, hilo_we}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  rop;
        logic [31:0] ra, rb;
        rst      = 1'b1;
        op_valid = 1'b0;
        flush    = 1'b0;
        hilo_op  = 6'd0;
        src_a    = 32'd0;
        src_b    = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_lo", {32'd0, lo_o}, 64'd0);
        chk("rst_stall", {63'd0, stallreq}, 64'd0);
        chk("rst_we", {62'd0, hilo_we}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("mthi", OP_MTHI, 32'h1234_5678, 32'd0);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero", OP_DIVU, 32'h8000_0000, 32'd0);
        run_op("div_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_mix", OP_MULT, 32'h8000_0000, 32'd3);
        run_op("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'd0);
        run_op("prio_div", 6'b111111, 32'd100, 32'd7);
        run_op("prio_multu", 6'b000111, 32'hF000_0001, 32'd16);
        run_op("prio_mthi", 6'b000011, 32'h0000_00AA, 32'd0);
        for (int i = 0; i < 10; i++) begin
            rop = 6'd1 << $urandom_range(0, 5);
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_op("rand", rop, ra, rb);
        end

        // flush in IDLE suppresses the accept
        @(posedge clk); #1;
        op_valid = 1'b1;
        hilo_op  = OP_MTHI;
        src_a    = 32'hDEAD_BEEF;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_idle_we", {62'd0, hilo_we}, 64'd0);
        chk("flush_idle_stall", {63'd0, stallreq}, 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        chk("flush_idle_hi", {32'd0, hi_o}, {32'd0, m_hi});

        // div accepted at T, flushed at T+10, mtlo at T+12
        @(posedge clk); #1;
        op_valid = 1'b1;
        hilo_op  = OP_DIV;
        src_a    = 32'd1000;
        src_b    = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_t10_stall", {63'd0, stallreq}, 64'd1);
        @(posedge clk); #1;
        flush    = 1'b0;
        op_valid = 1'b0;
        hilo_op  = 6'd0;
        @(negedge clk);
        chk("flush_t11_stall", {63'd0, stallreq}, 64'd0);
        chk("flush_t11_we", {62'd0, hilo_we}, 64'd0);
        chk("flush_t11_hi", {32'd0, hi_o}, {32'd0, m_hi});
        chk("flush_t11_lo", {32'd0, lo_o}, {32'd0, m_lo});
        run_op("post_flush_mtlo", OP_MTLO, 32'h0000_0055, 32'd0);

        // reset in the middle of an iterative op
        run_op("pre_rst_hi", OP_MTHI, 32'd5, 32'd0);
        run_op("pre_rst_lo", OP_MTLO, 32'd5, 32'd0);
        @(posedge clk); #1;
        op_valid = 1'b1;
`ifdef HILO_FAST_MUL_EN
        hilo_op = OP_DIV;
`else
        hilo_op = OP_MULT;
`endif
        src_a = 32'd7;
        src_b = 32'd9;
        repeat (5) @(posedge clk);
        #1;
        rst      = 1'b1;
        op_valid = 1'b0;
        hilo_op  = 6'd0;
        @(negedge clk);
        chk("rst_mid_stall", {63'd0, stallreq}, 64'd0);
        chk("rst_mid_we", {62'd0, hilo_we}, 64'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        chk("rst_after_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_after_lo", {32'd0, lo_o}, 64'd0);
        chk("rst_after_stall", {63'd0, stallreq}, 64'd0);
        run_op("post_rst_mthi", OP_MTHI, 32'd9, 32'd0);

        repeat (2) @(posedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 op_valid  in  1  a HI/LO-class instruction is in EX this cycle.
REQ-004 hilo_op  in  6  {div, divu, mult, multu, mthi, mtlo}, one-hot from ID.
REQ-005 src_a  in  32  rs operand; dividend, multiplicand, or mthi/mtlo data.
REQ-006 src_b  in  32  rt operand; divisor or multiplier.
REQ-007 flush  in  1  cancel the in-flight operation.
REQ-008 stallreq  out  1  pipeline hold request while an iterative op is busy.
REQ-009 hilo_we  out  2  {hi_we, lo_we}; forwarding write strobes for this cycle.
REQ-010 hi_i  out  32  value written to HI at the end of this cycle (forwarding).
REQ-011 lo_i  out  32  value written to LO at the end of this cycle (forwarding).
REQ-012 hi_o  out  32  architectural HI register.
REQ-013 lo_o  out  32  architectural LO register.

Function
REQ-014 States SHALL be IDLE, MUL, DIV and DONE; the unit SHALL accept a new op only in IDLE with op_valid=1.
REQ-015 Multiple hilo_op bits set SHALL resolve by priority: div > divu > mult > multu > mthi > mtlo.
REQ-016 mthi/mtlo SHALL complete in the accept cycle: hilo_we=10 (mthi) or 01 (mtlo), hi_i or lo_i = src_a, register updates at that edge, stallreq=0.
REQ-017 div/divu accepted at cycle T: operands latched; DIV state for cycles T+1..T+32 (one restoring radix-2 iteration per cycle); DONE at T+33.
REQ-018 Iterative mult/multu SHALL follow the same timing, using MUL state with one shift-add per cycle; DONE at T+33.
REQ-019 stallreq SHALL be 1 combinationally in the accept cycle T of an iterative op and in every MUL/DIV cycle, and 0 in DONE and IDLE.
REQ-020 In DONE: hilo_we=11, {hi_i, lo_i}=result, HI/LO update at that edge, next state IDLE; the still-asserted op_valid SHALL NOT be re-accepted in DONE.
REQ-021 The result of mult/multu SHALL be the 64-bit signed/unsigned product, with HI = bits 63:32 and LO = bits 31:0.
REQ-022 The result of div/divu SHALL be LO = quotient and HI = remainder.
REQ-023 Signed division SHALL operate on magnitudes: quotient sign = a^b, remainder sign = sign of a (truncating).
REQ-024 Divide by zero (signed or unsigned) SHALL give LO=32'hFFFF_FFFF, HI=src_a, with normal latency.
REQ-025 hilo_we SHALL be 00 whenever no write occurs this cycle; hi_i and lo_i are don't-care when the corresponding strobe is 0.
REQ-026 flush=1 in MUL/DIV SHALL return the unit to IDLE at that edge with no HI/LO write; stallreq SHALL be 0 from the following cycle.
REQ-027 flush=1 in IDLE or DONE SHALL suppress that cycle's accept/write (hilo_we=00).

Reset
REQ-028 rst SHALL force IDLE, HI=0, LO=0, stallreq=0, hilo_we=00, and clear iteration counters; it takes priority over flush and op_valid.
REQ-029 rst during MUL/DIV SHALL discard the operation with no write.

Configuration
REQ-030 Macro HILO_FAST_MUL_EN: when defined, mult/multu SHALL complete in the accept cycle like mthi (single-cycle 32x32 product, hilo_we=11, stallreq=0, MUL state unused).
REQ-031 When HILO_FAST_MUL_EN is undefined, mult/multu SHALL use the 33-cycle iterative path of REQ-018; div is iterative in both builds.

Verification
REQ-032 mthi, src_a=0x12345678: same cycle hilo_we=10, hi_i=0x12345678; next cycle hi_o=0x12345678, lo_o unchanged.
REQ-033 div, a=0xFFFFFFF9 (-7), b=2: stallreq=1 for 33 cycles; DONE gives LO=0xFFFFFFFD, HI=0xFFFFFFFF, hilo_we=11.
REQ-034 divu, a=0x80000000, b=0: after 33 cycles LO=0xFFFFFFFF, HI=0x80000000.
REQ-035 mult 0xFFFFFFFF x 0xFFFFFFFF -> HI=0, LO=1; multu same operands -> HI=0xFFFFFFFE, LO=1; latency 0 stall cycles with HILO_FAST_MUL_EN, 33 stall cycles without.
REQ-036 div started at T, flush at T+10: no write, HI/LO unchanged, stallreq=0 at T+11, a new mtlo at T+12 is accepted.
REQ-037 rst at T+5 of an iterative mult after HI=LO=5: HI=LO=0, stallreq=0, IDLE next cycle.
